// File: rtl/icache_refill_arbiter_pkg.sv
// icache_refill_arbiter_pkg
//   Shared definitions for the L1 refill arbiter: FSM state encoding,
//   requester ids, line geometry and default parameter values.
package icache_refill_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_e;

  // Requester ids double as bit positions in the req/grant vectors.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // 16-byte lines: the low four address bits select a byte inside the line.
  localparam int LINE_OFFSET_BITS = 4;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_LINE_W  = 128;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Combinational two-requester round-robin arbiter.
//   Ports:
//     req[1:0]    request vector, bit REQ_I = icache, bit REQ_D = dcache
//     last_grant  id of the requester served last (register lives in parent)
//     grant[1:0]  one-hot winner, or zero when nobody requests
module rr_arb2
  import icache_refill_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    // On a tie the side that was not served last wins.
    if (req == 2'b11) begin
      grant = (last_grant == REQ_D) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/icache_refill_arbiter.sv
// icache_refill_arbiter
//   Shares one main-memory line-read port between the instruction and data
//   caches. Round-robin arbitration, one aligned line read per grant, result
//   returned to the winner with a single-cycle valid pulse.
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     I_REQ/I_ADDR           icache refill request (level) and miss address
//     I_VALID/I_LINE         icache refill pulse and held line data
//     D_REQ/D_ADDR           dcache refill request (level) and miss address
//     D_VALID/D_LINE         dcache refill pulse and held line data
//     MEM_RD/MEM_ADDR        one-cycle read strobe and line-aligned address
//     MEM_ACK/MEM_RDATA      one-cycle memory acknowledge with line data
//     BUSY                   high whenever the FSM is not IDLE
//     ERR                    sticky memory timeout flag, cleared only by rst
//
// Handshake: a requester raises REQ with ADDR and holds both until its VALID
// pulse; REQ/ADDR are sampled only in IDLE, so later changes do not affect a
// service in flight and a dropped REQ still gets its VALID. Memory sees one
// MEM_RD strobe per service and must answer with one MEM_ACK; acks that do
// not arrive in WAIT are discarded.
module icache_refill_arbiter
  import icache_refill_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic              I_VALID,
  output logic [LINE_W-1:0] I_LINE,
  input  logic              D_REQ,
  input  logic [ADDR_W-1:0] D_ADDR,
  output logic              D_VALID,
  output logic [LINE_W-1:0] D_LINE,
  output logic              MEM_RD,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [LINE_W-1:0] MEM_RDATA,
  output logic              BUSY,
  output logic              ERR
);

  localparam logic [1:0] ST_IDLE    = S_IDLE;
  localparam logic [1:0] ST_ISSUE   = S_ISSUE;
  localparam logic [1:0] ST_WAIT    = S_WAIT;
  localparam logic [1:0] ST_DELIVER = S_DELIVER;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

  logic [1:0]        state_q;
  logic              win_q;      // id of the requester being served
  logic              ptr_q;      // id of the requester served last
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic [LINE_W-1:0] i_line_q;
  logic [LINE_W-1:0] d_line_q;

  logic [1:0]        grant;
  logic [ADDR_W-1:0] sel_addr;

  rr_arb2 u_arb (
    .req        ({D_REQ, I_REQ}),
    .last_grant (ptr_q),
    .grant      (grant)
  );

  assign sel_addr = grant[REQ_D] ? D_ADDR : I_ADDR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      win_q    <= REQ_I;
      ptr_q    <= REQ_D;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      i_line_q <= '0;
      d_line_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            win_q   <= grant[REQ_D];
            addr_q  <= sel_addr & LINE_MASK;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // An ack on the final allowed cycle still counts as a success.
          if (MEM_ACK) begin
            if (win_q == REQ_D) d_line_q <= MEM_RDATA;
            else                i_line_q <= MEM_RDATA;
            state_q <= ST_DELIVER;
          end else if (cnt_q == CNT_LAST) begin
            // Abort without delivery; a still-raised REQ is simply re-arbitrated.
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DELIVER: begin
          ptr_q   <= win_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MEM_RD   = (state_q == ST_ISSUE);
  assign MEM_ADDR = addr_q;
  assign I_VALID  = (state_q == ST_DELIVER) && (win_q == REQ_I);
  assign D_VALID  = (state_q == ST_DELIVER) && (win_q == REQ_D);
  assign I_LINE   = i_line_q;
  assign D_LINE   = d_line_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign ERR      = err_q;

endmodule

// File: doc/icache_refill_arbiter.md
# icache_refill_arbiter

- Shares the single main-memory line-read port between the instruction cache and the data cache. Each cache raises a request on a miss.
- The block arbitrates round-robin, issues one aligned 128-bit line read and waits for the memory acknowledge. It then returns the line to the winning requester with a one-cycle valid pulse.
- Sits between both L1 caches and the memory interface of the 32-bit RISC core, and replaces each cache's private fixed-delay refill counter.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- LINE_W, 128, cache line width (4 x 32-bit words)
- TIMEOUT, 64, maximum cycles spent in WAIT before an abort

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- I_REQ  in  1  instruction-cache refill request, level
- I_ADDR  in  ADDR_W  instruction miss address
- I_VALID  out  1  one-cycle pulse: I_LINE holds the refilled line
- I_LINE  out  LINE_W  line data for the instruction cache
- D_REQ  in  1  data-cache refill request, level
- D_ADDR  in  ADDR_W  data miss address
- D_VALID  out  1  one-cycle pulse: D_LINE holds the refilled line
- D_LINE  out  LINE_W  line data for the data cache
- MEM_RD  out  1  one-cycle read strobe to memory
- MEM_ADDR  out  ADDR_W  line-aligned read address
- MEM_ACK  in  1  one-cycle pulse: MEM_RDATA is valid
- MEM_RDATA  in  LINE_W  line returned by memory
- BUSY  out  1  high in every state except IDLE
- ERR  out  1  sticky timeout flag; cleared only by rst

## Operation
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- **IDLE:**
  - If any request is high, latch the winner, its line address and its requester id, then go to ISSUE.
  - Otherwise stay in IDLE.
- **Arbitration:**
  - If only one request is high, that requester wins.
  - If both are high, the requester not granted last wins.
  - The last-grant pointer resets to D, so I wins the first tie after reset.
- **Address:** MEM_ADDR = {ADDR[ADDR_W-1:4], 4'b0000}. It is registered at grant and held constant through ISSUE and WAIT.
- **ISSUE:**
  - MEM_RD = 1 for exactly this cycle, then go to WAIT.
  - MEM_ACK during ISSUE is ignored.
- **WAIT:**
  - On MEM_ACK, capture MEM_RDATA into the winner's line register and go to DELIVER.
  - A timeout counter, cleared on entry, increments each WAIT cycle.
  - When it reaches TIMEOUT-1 with no ack: set ERR, deliver nothing and go to IDLE. The requester's REQ is still high and is re-arbitrated normally.
- **DELIVER:**
  - Pulse the winner's VALID for one cycle and update the last-grant pointer.
  - Go to IDLE.
  - The loser's line register is untouched.
- **Line registers:** I_LINE and D_LINE hold their last delivered value until the next delivery to that side.
- **Requester protocol:** hold REQ and ADDR stable until VALID. If REQ drops mid-service, the service still completes and VALID still pulses. ADDR changes after grant are ignored.
- **Ignored inputs:** MEM_ACK outside WAIT is ignored, which covers stray or late acks.
- **Reset:**
  - rst in any state immediately forces IDLE on the next edge.
  - Outputs after reset: MEM_RD=0, MEM_ADDR=0, I_VALID=0, D_VALID=0, I_LINE=0, D_LINE=0, BUSY=0, ERR=0; pointer=D; timeout counter=0.
  - An in-flight read is abandoned. Its later ack arrives in IDLE and is ignored.
- A requester never receives two VALIDs for one request. I_VALID and D_VALID are never high together.

## Timing
- Cycle 0: REQ sampled high in IDLE.
- Cycle 1: ISSUE, MEM_RD=1.
- Cycle 1+k (k≥1): MEM_ACK in WAIT.
- Cycle 2+k: DELIVER, VALID=1.
- Cycle 3+k: IDLE, earliest next grant.
- Minimum request-to-VALID latency is 3 cycles with k=1. A memory with 5-cycle latency gives 7.
- Back-to-back service: the second requester's MEM_RD comes 3+k cycles after the first's.
- BUSY rises the cycle after the grant (ISSUE) and falls in the cycle after DELIVER.
- Timeout abort: ERR rises on the edge leaving WAIT, TIMEOUT cycles after WAIT entry.

## Structure
- Shared package contents:
  - state encoding enum (IDLE, ISSUE, WAIT, DELIVER)
  - requester-id constants (REQ_I=0, REQ_D=1)
  - LINE_OFFSET_BITS=4
  - default LINE_W and TIMEOUT
- One sub-module, rr_arb2: a two-requester round-robin arbiter.
  - Inputs: req[1:0], last-grant pointer.
  - Output: grant[1:0], one-hot or zero.
  - Combinational. The pointer register lives in the parent.
- Everything else is in the single top-level module.

## Test plan
- **Single I miss:** I_REQ=1, I_ADDR=0x0000_1234, memory acks 5 cycles after MEM_RD with 0xA5..A5 -> MEM_ADDR=0x0000_1230, one MEM_RD, I_VALID at cycle 7, I_LINE=0xA5..A5, D_VALID never high.
- **Simultaneous requests after reset:** I_REQ=D_REQ=1 at cycle 0 -> I served first. D's MEM_RD follows at cycle 1+3+k. Repeating the tie alternates D, I, D.
- **Ack edge cases:** MEM_ACK asserted during ISSUE and during IDLE -> no state change and no VALID. Only the WAIT ack is delivered.
- **Timeout:** TIMEOUT=8, memory never acks -> ERR=1 after 8 WAIT cycles, no VALID, I re-granted next IDLE. ERR stays 1 until rst.
- **Reset mid-operation:** rst in WAIT, then a late MEM_ACK -> all outputs at reset values, no VALID, BUSY=0. The next request is served normally.
- **Line hold:** serve D with 0x1111.., then I with 0x2222.. -> D_LINE keeps 0x1111.. throughout the I service.
